// File: rtl/thor2025_preg_freelist.sv
// Physical register free list for the Thor2025 renamer: offers two tags per cycle,
// takes back three per cycle, and keeps checkpoints for branch-miss backout.
module thor2025_preg_freelist #(
    parameter int NPREG  = 128,
    parameter int NCHECK = 8,
    localparam int TW    = $clog2(NPREG),
    localparam int CW    = $clog2(NCHECK),
    localparam int NW    = $clog2(NPREG + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    alloc_cnt,
    output logic [TW-1:0] tag0,
    output logic [TW-1:0] tag1,
    output logic          v0,
    output logic          v1,
    input  logic [2:0]    fv,
    input  logic [TW-1:0] fta,
    input  logic [TW-1:0] ftb,
    input  logic [TW-1:0] ftc,
    input  logic          cp,
    input  logic [CW-1:0] cp_ndx,
    input  logic          rs,
    input  logic [CW-1:0] rs_ndx,
    output logic [NW-1:0] free_cnt,
    output logic          err_ovf,
    output logic          err_dfree
);

    logic [NPREG-1:0] avail;
    logic [NPREG-1:0] snap  [NCHECK];
    logic [NPREG-1:0] since [NCHECK];

    logic [NPREG-1:0] grant, freed, avail_nx;
    logic [TW-1:0]    ft [3];
    logic [1:0]       req;
    logic             ovf, dfree;
    logic [TW-1:0]    t0, t1;
    logic             f0, f1;
    logic [NW-1:0]    cnt;

    always_comb begin
        grant = '0;
        ovf   = 1'b0;
        req   = (alloc_cnt == 2'd3) ? 2'd2 : alloc_cnt;
        // A restore discards this cycle's allocation entirely.
        if (!rs) begin
            if (req >= 2'd1) begin
                if (v0) grant[tag0] = 1'b1;
                else    ovf = 1'b1;
            end
            if (req == 2'd2) begin
                if (v1) grant[tag1] = 1'b1;
                else    ovf = 1'b1;
            end
        end
    end

    always_comb begin
        ft[0] = fta;
        ft[1] = ftb;
        ft[2] = ftc;
        freed = '0;
        dfree = 1'b0;
        // Tag 0 is the map's unmapped value: freeing it is silently ignored.
        for (int i = 0; i < 3; i++) begin
            if (fv[i] && ft[i] != '0) begin
                if (freed[ft[i]] || (avail[ft[i]] && !grant[ft[i]]))
                    dfree = 1'b1;
                freed[ft[i]] = 1'b1;
            end
        end
    end

    always_comb begin
        if (rs) avail_nx = snap[rs_ndx] | since[rs_ndx] | freed;
        else    avail_nx = (avail & ~grant) | freed;
        avail_nx[0] = 1'b0;
    end

    always_comb begin
        t0  = '0;
        t1  = '0;
        f0  = 1'b0;
        f1  = 1'b0;
        cnt = '0;
        for (int i = 1; i < NPREG; i++) begin
            if (avail_nx[i]) begin
                cnt = cnt + 1'b1;
                if (!f0) begin
                    f0 = 1'b1;
                    t0 = TW'(i);
                end else if (!f1) begin
                    f1 = 1'b1;
                    t1 = TW'(i);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            avail     <= {{(NPREG-1){1'b1}}, 1'b0};
            tag0      <= TW'(1);
            tag1      <= TW'(2);
            v0        <= 1'b1;
            v1        <= 1'b1;
            free_cnt  <= NW'(NPREG - 1);
            err_ovf   <= 1'b0;
            err_dfree <= 1'b0;
            for (int k = 0; k < NCHECK; k++) begin
                snap[k]  <= '0;
                since[k] <= '0;
            end
        end else begin
            avail     <= avail_nx;
            tag0      <= t0;
            tag1      <= t1;
            v0        <= f0;
            v1        <= f1;
            free_cnt  <= cnt;
            err_ovf   <= err_ovf | ovf;
            err_dfree <= err_dfree | dfree;
            for (int k = 0; k < NCHECK; k++)
                since[k] <= since[k] | freed;
            // This cycle's frees are already in the snapshot, so since restarts empty.
            if (cp && !rs) begin
                snap[cp_ndx]  <= avail_nx;
                since[cp_ndx] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_thor2025_preg_freelist.sv
// Directed bench for the Thor2025 physical register free list.
module tb_thor2025_preg_freelist;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] alloc_cnt;
    logic [6:0] tag0, tag1;
    logic       v0, v1;
    logic [2:0] fv;
    logic [6:0] fta, ftb, ftc;
    logic       cp;
    logic [2:0] cp_ndx;
    logic       rs;
    logic [2:0] rs_ndx;
    logic [7:0] free_cnt;
    logic       err_ovf, err_dfree;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    thor2025_preg_freelist dut (
        .clk(clk), .rst(rst), .alloc_cnt(alloc_cnt),
        .tag0(tag0), .tag1(tag1), .v0(v0), .v1(v1),
        .fv(fv), .fta(fta), .ftb(ftb), .ftc(ftc),
        .cp(cp), .cp_ndx(cp_ndx), .rs(rs), .rs_ndx(rs_ndx),
        .free_cnt(free_cnt), .err_ovf(err_ovf), .err_dfree(err_dfree)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; alloc_cnt = 2'd0; fv = 3'b000;
        fta = '0; ftb = '0; ftc = '0;
        cp = 1'b0; cp_ndx = '0; rs = 1'b0; rs_ndx = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
    endtask

    initial begin
        idle();
        do_reset();
        check("rst_tag0", tag0, 1);
        check("rst_tag1", tag1, 2);
        check("rst_v0", v0, 1);
        check("rst_v1", v1, 1);
        check("rst_cnt", free_cnt, 127);
        check("rst_ovf", err_ovf, 0);
        check("rst_dfree", err_dfree, 0);

        alloc_cnt = 2'd2; step();
        check("a1_tag0", tag0, 3);
        check("a1_tag1", tag1, 4);
        check("a1_cnt", free_cnt, 125);
        alloc_cnt = 2'd2; step();
        check("a2_tag0", tag0, 5);
        check("a2_cnt", free_cnt, 123);
        alloc_cnt = 2'd2; step();
        check("a3_tag0", tag0, 7);
        check("a3_tag1", tag1, 8);
        check("a3_cnt", free_cnt, 121);

        for (int i = 0; i < 60; i++) begin
            alloc_cnt = 2'd2;
            step();
        end
        check("drain_cnt", free_cnt, 1);
        check("drain_tag0", tag0, 127);
        check("drain_v0", v0, 1);
        check("drain_v1", v1, 0);
        check("drain_tag1", tag1, 0);
        check("drain_ovf0", err_ovf, 0);
        alloc_cnt = 2'd2; step();
        check("ovf_set", err_ovf, 1);
        check("empty_v0", v0, 0);
        check("empty_v1", v1, 0);
        check("empty_cnt", free_cnt, 0);
        check("empty_tag0", tag0, 0);
        step();
        check("ovf_sticky", err_ovf, 1);

        do_reset();
        check("ovf_cleared", err_ovf, 0);
        alloc_cnt = 2'd2; step();
        alloc_cnt = 2'd2; step();
        fv = 3'b011; fta = 7'd2; ftb = 7'd3; step();
        check("free_tag0", tag0, 2);
        check("free_tag1", tag1, 3);
        check("free_cnt", free_cnt, 125);
        check("free_nodfree", err_dfree, 0);

        do_reset();
        alloc_cnt = 2'd2; step();
        alloc_cnt = 2'd2; cp = 1'b1; cp_ndx = 3'd3; step();
        alloc_cnt = 2'd2; step();
        alloc_cnt = 2'd2; step();
        fv = 3'b001; fta = 7'd1; step();
        check("pre_rs_tag0", tag0, 1);
        check("pre_rs_tag1", tag1, 9);
        check("pre_rs_cnt", free_cnt, 120);
        rs = 1'b1; rs_ndx = 3'd3; step();
        check("rs_tag0", tag0, 1);
        check("rs_tag1", tag1, 5);
        check("rs_cnt", free_cnt, 124);

        fv = 3'b001; fta = 7'd10; step();
        check("dfree_set", err_dfree, 1);
        check("dfree_cnt", free_cnt, 124);
        check("dfree_tag0", tag0, 1);

        do_reset();
        fv = 3'b001; fta = 7'd0; step();
        check("free0_dfree", err_dfree, 0);
        check("free0_cnt", free_cnt, 127);
        check("free0_tag0", tag0, 1);
        alloc_cnt = 2'd1; step();
        check("a1only_tag0", tag0, 2);
        check("a1only_cnt", free_cnt, 126);
        fv = 3'b011; fta = 7'd1; ftb = 7'd1; step();
        check("dup_dfree", err_dfree, 1);
        check("dup_tag0", tag0, 1);
        check("dup_cnt", free_cnt, 127);

        do_reset();
        alloc_cnt = 2'd3; cp = 1'b1; cp_ndx = 3'd2; step();
        check("cnt3_tag0", tag0, 3);
        check("cnt3_cnt", free_cnt, 125);
        alloc_cnt = 2'd2; step();
        check("pre_rscp_tag0", tag0, 5);
        rs = 1'b1; rs_ndx = 3'd2; cp = 1'b1; cp_ndx = 3'd5; alloc_cnt = 2'd2; step();
        check("rscp_tag0", tag0, 3);
        check("rscp_tag1", tag1, 4);
        check("rscp_cnt", free_cnt, 125);
        check("rscp_ovf", err_ovf, 0);
        rs = 1'b1; rs_ndx = 3'd5; step();
        check("cp5_untouched_cnt", free_cnt, 0);
        check("cp5_untouched_v0", v0, 0);

        alloc_cnt = 2'd2; rst = 1'b1; step();
        check("midrst_tag0", tag0, 1);
        check("midrst_cnt", free_cnt, 127);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
